// File: rtl/mem_layout_pkg.sv
// Shared layout constants and the BIST sequencer state type.
package mem_layout_pkg;

   localparam int BIST_NUM_TESTS = 7;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } bist_state_t;

endpackage

// File: rtl/bist_watchdog.sv
// Per-engine watchdog for bist_sequencer; only instantiated when BIST_TIMEOUT_EN is defined.
module bist_watchdog #(
   parameter  int TIMEOUT_CYCLES = 2**20,
   localparam int WW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0] count;

   // count holds the number of enabled cycles before the current one, so expiry
   // fires on the TIMEOUT_CYCLES-th enabled cycle itself
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/bist_sequencer.sv
// Runs NUM_TESTS self-test engines one at a time and collects pass/fail results.
// Define BIST_TIMEOUT_EN to add a per-engine watchdog (timeout_mask is 0 otherwise).
module bist_sequencer
   import mem_layout_pkg::*;
#(
   parameter  int NUM_TESTS      = BIST_NUM_TESTS,
   parameter  int START_IDX      = 0,
   parameter  int RUN_COUNT      = -1,
   parameter  int TIMEOUT_CYCLES = 2**20,
   localparam int CW             = $clog2(NUM_TESTS + 1),
   localparam int IW             = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   output logic [NUM_TESTS-1:0] test_start,
   input  logic [NUM_TESTS-1:0] test_done,
   input  logic [NUM_TESTS-1:0] test_pass,
   output logic                 busy,
   output logic                 suite_done,
   output logic [IW-1:0]        cur_idx,
   output logic [CW-1:0]        pass_cnt,
   output logic [CW-1:0]        fail_cnt,
   output logic [CW-1:0]        run_cnt,
   output logic [NUM_TESTS-1:0] pass_mask,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [NUM_TESTS-1:0] timeout_mask
);

   bist_state_t          state;
   bist_state_t          state_nxt;
   logic [NUM_TESTS-1:0] sel;
   logic                 done_cur;
   logic                 pass_cur;
   logic                 timeout_hit;
   logic                 finish;
   logic                 last;
   logic                 start_suite;

   always_comb begin
      sel = NUM_TESTS'(1) << cur_idx;
   end

   assign done_cur    = |(test_done & sel);
   assign pass_cur    = |(test_pass & sel);
   assign finish      = done_cur || timeout_hit;
   assign start_suite = go && ((state == IDLE) || (state == DONE));
   assign last        = (cur_idx == IW'(NUM_TESTS - 1)) ||
                        ((RUN_COUNT != -1) && ((int'(run_cnt) + 1) == RUN_COUNT));

`ifdef BIST_TIMEOUT_EN
   logic expired;

   bist_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == LAUNCH),
      .enable (state == WAIT),
      .expired(expired)
   );

   // done in the expiry cycle takes precedence over the timeout
   assign timeout_hit = expired && !done_cur;

   always_ff @(posedge clk) begin
      if (rst || start_suite) begin
         timeout_mask <= '0;
      end else if ((state == WAIT) && timeout_hit) begin
         timeout_mask <= timeout_mask | sel;
      end
   end
`else
   assign timeout_hit  = 1'b0;
   assign timeout_mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (go) state_nxt = LAUNCH;
         LAUNCH:     state_nxt = WAIT;
         WAIT:       if (finish) state_nxt = last ? DONE : LAUNCH;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      test_start = (state == LAUNCH) ? sel : '0;
      busy       = (state == LAUNCH) || (state == WAIT);
      suite_done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_idx   <= '0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         run_cnt   <= '0;
         pass_mask <= '0;
         fail_mask <= '0;
      end else if (start_suite) begin
         cur_idx   <= IW'(START_IDX);
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         run_cnt   <= '0;
         pass_mask <= '0;
         fail_mask <= '0;
      end else if ((state == WAIT) && finish) begin
         run_cnt <= run_cnt + 1'b1;
         if (done_cur && pass_cur) begin
            pass_cnt  <= pass_cnt + 1'b1;
            pass_mask <= pass_mask | sel;
         end else begin
            fail_cnt  <= fail_cnt + 1'b1;
            fail_mask <= fail_mask | sel;
         end
         if (!last) begin
            cur_idx <= cur_idx + 1'b1;
         end
      end
   end

endmodule

// File: doc/bist_sequencer.md
# bist_sequencer

Synthesizable self-test scheduler. It runs a bank of `NUM_TESTS` self-test engines one at a time: it issues a start pulse to each, waits for that engine's done, records pass/fail, then moves to the next. It sits above the DAC/ADC/PWL self-test engines and gives firmware a single go/busy/results interface for a full suite run.

## Interface
Parameters:
- `NUM_TESTS`, 7: number of engines; ≥1.
- `START_IDX`, 0: first engine run (0-indexed); < `NUM_TESTS`.
- `RUN_COUNT`, -1: maximum engines run per suite; -1 means run through the last index.
- `TIMEOUT_CYCLES`, 2**20: watchdog limit per engine (used only with `BIST_TIMEOUT_EN`).

Ports (CW = `$clog2(NUM_TESTS+1)`, IW = `$clog2(NUM_TESTS)` min 1):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: start a suite. Level is sampled every cycle and acts only in IDLE/DONE.
- `test_start` out `NUM_TESTS`: one-hot, one-cycle start pulse.
- `test_done` in `NUM_TESTS`: per-engine done. Only the bit for the current index is observed.
- `test_pass` in `NUM_TESTS`: per-engine result. Sampled with the current index's done.
- `busy` out 1: high from LAUNCH through WAIT.
- `suite_done` out 1: high in DONE.
- `cur_idx` out IW: index of the engine currently running or last run.
- `pass_cnt`, `fail_cnt`, `run_cnt` out CW each: result counters.
- `pass_mask`, `fail_mask`, `timeout_mask` out `NUM_TESTS`: per-engine results.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- **IDLE**: all outputs are 0 (this is also the reset state). `go` sets `cur_idx`=`START_IDX`, clears counters and masks, and moves to LAUNCH.
- **LAUNCH**: `test_start[cur_idx]`=1 for exactly this cycle, then unconditionally to WAIT.
- **WAIT**: watches `test_done[cur_idx]`. On done:
  - `run_cnt`++.
  - If `test_pass[cur_idx]` is high: `pass_cnt`++ and set `pass_mask[cur_idx]`. Otherwise: `fail_cnt`++ and set `fail_mask[cur_idx]`.
  - Go to DONE if `cur_idx`==`NUM_TESTS-1` or (`RUN_COUNT`≠-1 and `run_cnt`+1==`RUN_COUNT`). Otherwise `cur_idx`++ and go to LAUNCH.
- **DONE**: counters and masks hold. `go` restarts exactly as from IDLE, clearing prior results.
- `go` while `busy` is ignored.
- Done bits from non-current engines are ignored in every state.
- A done that is already high when WAIT is entered counts on the first WAIT cycle. Engines must deassert done before their next start.
- `rst` at any point, including mid-WAIT, forces IDLE next cycle: `test_start`=0, all counters and masks 0, no partial result recorded.
- Invariant: `pass_cnt`+`fail_cnt`==`run_cnt` ≤ `NUM_TESTS`-`START_IDX`.

## Timing
- `go` high at edge N → `test_start[START_IDX]` high in cycle N+1 and `busy` rises in cycle N+1.
- `test_done[cur]` high in cycle K (K ≥ start cycle+1) → the counter/mask update and the next start are both visible in cycle K+1. Engine-to-engine overhead is 1 cycle.
- On the final engine, `busy` falls and `suite_done` rises in cycle K+1.
- `test_start` is decoded from the state register and `cur_idx`; it is glitch-free relative to `clk`.

## Configuration
- `BIST_TIMEOUT_EN` defined:
  - A watchdog counts WAIT cycles and clears on entry to LAUNCH.
  - When the count reaches `TIMEOUT_CYCLES` with no done: the engine is treated as failed (`fail_cnt`++, `fail_mask` bit set), `timeout_mask[cur_idx]` is set, and the FSM advances exactly as on done.
  - Done and timeout in the same cycle: done wins and no timeout is recorded.
- Undefined: no watchdog logic, WAIT holds indefinitely, `timeout_mask` tied to 0.

## Structure
- `mem_layout_pkg` gains:
  - `bist_state_t` enum {IDLE, LAUNCH, WAIT, DONE}.
  - `BIST_NUM_TESTS` constant, so firmware register maps share the count.
- Sub-module `bist_watchdog`, instantiated only under `BIST_TIMEOUT_EN`:
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: `expired`.
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Full suite: `NUM_TESTS`=4, each engine returns done+pass 3 cycles after its start, engine 2 fails → `pass_cnt`=3, `fail_cnt`=1, `fail_mask`=4'b0100, `suite_done` 1 cycle after the last done.
- Partial run: `START_IDX`=1, `RUN_COUNT`=2 → starts seen only on bits 1 and 2, `run_cnt`=2, bit 3 never pulsed.
- Stray done: assert `test_done[3]` while index 1 is running → no state change, and no start pulse to engine 3 until its turn.
- `go` while busy plus restart: pulse `go` during WAIT → ignored. `go` in DONE → counters clear to 0 the next cycle and `test_start[START_IDX]` is high the cycle after `go`.
- Reset mid-WAIT: assert `rst` while engine 1 is in WAIT → IDLE next cycle, all outputs 0; a following done from engine 1 is ignored.
- With `BIST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, engine 0 never signals done → `timeout_mask[0]`=1 and `fail_cnt`=1 after 16 WAIT cycles, and `test_start[1]` pulses the next cycle.
